// File: rtl/fp_pkg.sv
// Shared opcodes, IEEE-754 single-precision constants and FSM states
// for the FP operation arbiter.
package fp_pkg;

  localparam logic [1:0] OP_ADD = 2'b00;
  localparam logic [1:0] OP_MUL = 2'b01;
  localparam logic [1:0] OP_DIV = 2'b10;
  localparam logic [1:0] OP_RSV = 2'b11;

  localparam logic [31:0] FP_ONE = 32'h3F800000;
  localparam logic [31:0] FP_TWO = 32'h40000000;
  localparam logic [31:0] FP_NAN = 32'h7FC00000;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2,
    S_RESP  = 2'd3
  } arb_state_e;

endpackage

// File: rtl/fp_op_arbiter_rr_pick.sv
// Combinational round-robin picker: first valid index at or after ptr_i,
// wrapping modulo NUM_REQ.
module rr_pick
  import fp_pkg::*;
#(
  parameter int NUM_REQ = 3,
  parameter int IDXW    = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] valid_i,
  input  logic [IDXW-1:0]    ptr_i,
  output logic [NUM_REQ-1:0] grant_o,
  output logic [IDXW-1:0]    idx_o,
  output logic               any_o
);

  // Scan from the farthest offset down so the nearest valid index wins.
  always_comb begin
    logic [IDXW-1:0] j;
    grant_o = '0;
    idx_o   = '0;
    any_o   = 1'b0;
    j       = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      j = IDXW'((int'(ptr_i) + k) % NUM_REQ);
      if (valid_i[j]) begin
        grant_o    = '0;
        grant_o[j] = 1'b1;
        idx_o      = j;
        any_o      = 1'b1;
      end
    end
  end

endmodule

// File: rtl/fp_op_arbiter.sv
// Round-robin scheduler sharing one FP add/mul/div unit among NUM_REQ requesters.
// Grant counters on stat_grants are built only when FP_ARB_STATS_EN is defined.
module fp_op_arbiter
  import fp_pkg::*;
#(
  parameter int NUM_REQ = 3,
  parameter int TIMEOUT = 64
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [NUM_REQ-1:0]      req_valid,
  output logic [NUM_REQ-1:0]      req_ready,
  input  logic [2*NUM_REQ-1:0]    req_op,
  input  logic [32*NUM_REQ-1:0]   req_a,
  input  logic [32*NUM_REQ-1:0]   req_b,
  output logic [NUM_REQ-1:0]      resp_valid,
  input  logic [NUM_REQ-1:0]      resp_ready,
  output logic [31:0]             resp_data,
  output logic                    resp_err,
  output logic                    fu_start,
  output logic [1:0]              fu_op,
  output logic [31:0]             fu_a,
  output logic [31:0]             fu_b,
  input  logic                    fu_done,
  input  logic [31:0]             fu_result,
  output logic                    fu_flush,
  output logic                    busy,
  output logic [16*NUM_REQ-1:0]   stat_grants
);

  localparam int IDXW = $clog2(NUM_REQ);

  arb_state_e      state_q, state_d;
  logic [IDXW-1:0] rr_ptr_q, rr_ptr_d;
  logic [IDXW-1:0] owner_q, owner_d;
  logic [7:0]      cnt_q, cnt_d;
  logic [1:0]      fu_op_q, fu_op_d;
  logic [31:0]     fu_a_q, fu_a_d;
  logic [31:0]     fu_b_q, fu_b_d;
  logic [31:0]     resp_data_q, resp_data_d;
  logic            resp_err_q, resp_err_d;

  logic [1:0]  op_arr [NUM_REQ];
  logic [31:0] a_arr  [NUM_REQ];
  logic [31:0] b_arr  [NUM_REQ];

  logic [NUM_REQ-1:0] pick_grant;
  logic [IDXW-1:0]    pick_idx;
  logic               pick_any;
  logic [8:0]         cnt_inc;
  logic               timeout_hit;

  for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_unpack
    assign op_arr[gi] = req_op[2*gi +: 2];
    assign a_arr[gi]  = req_a[32*gi +: 32];
    assign b_arr[gi]  = req_b[32*gi +: 32];
  end

  rr_pick #(
    .NUM_REQ (NUM_REQ),
    .IDXW    (IDXW)
  ) u_pick (
    .valid_i (req_valid),
    .ptr_i   (rr_ptr_q),
    .grant_o (pick_grant),
    .idx_o   (pick_idx),
    .any_o   (pick_any)
  );

  assign cnt_inc     = {1'b0, cnt_q} + 9'd1;
  assign timeout_hit = (cnt_inc == 9'(TIMEOUT));

  always_comb begin
    state_d     = state_q;
    rr_ptr_d    = rr_ptr_q;
    owner_d     = owner_q;
    cnt_d       = cnt_q;
    fu_op_d     = fu_op_q;
    fu_a_d      = fu_a_q;
    fu_b_d      = fu_b_q;
    resp_data_d = resp_data_q;
    resp_err_d  = resp_err_q;
    req_ready   = '0;
    fu_start    = 1'b0;
    fu_flush    = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (pick_any && !rst) begin
          req_ready = pick_grant;
          fu_op_d   = op_arr[pick_idx];
          fu_a_d    = a_arr[pick_idx];
          fu_b_d    = b_arr[pick_idx];
          owner_d   = pick_idx;
          rr_ptr_d  = IDXW'((int'(pick_idx) + 1) % NUM_REQ);
          // Reserved opcode never reaches the unit; answer with a NaN error.
          if (op_arr[pick_idx] == OP_RSV) begin
            resp_data_d = FP_NAN;
            resp_err_d  = 1'b1;
            state_d     = S_RESP;
          end else begin
            state_d = S_ISSUE;
          end
        end
      end
      S_ISSUE: begin
        fu_start = !rst;
        cnt_d    = '0;
        state_d  = S_WAIT;
      end
      S_WAIT: begin
        cnt_d = cnt_q + 8'd1;
        // A completion on the timeout cycle still counts as success.
        if (fu_done) begin
          resp_data_d = fu_result;
          resp_err_d  = 1'b0;
          state_d     = S_RESP;
        end else if (timeout_hit) begin
          fu_flush    = !rst;
          resp_data_d = FP_NAN;
          resp_err_d  = 1'b1;
          state_d     = S_RESP;
        end
      end
      S_RESP: begin
        if (resp_ready[owner_q]) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      rr_ptr_q    <= '0;
      owner_q     <= '0;
      cnt_q       <= '0;
      fu_op_q     <= '0;
      fu_a_q      <= '0;
      fu_b_q      <= '0;
      resp_data_q <= '0;
      resp_err_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      rr_ptr_q    <= rr_ptr_d;
      owner_q     <= owner_d;
      cnt_q       <= cnt_d;
      fu_op_q     <= fu_op_d;
      fu_a_q      <= fu_a_d;
      fu_b_q      <= fu_b_d;
      resp_data_q <= resp_data_d;
      resp_err_q  <= resp_err_d;
    end
  end

  for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_resp
    assign resp_valid[gi] = (state_q == S_RESP) && (owner_q == IDXW'(gi));
  end

  assign resp_data = resp_data_q;
  assign resp_err  = resp_err_q;
  assign fu_op     = fu_op_q;
  assign fu_a      = fu_a_q;
  assign fu_b      = fu_b_q;
  assign busy      = (state_q != S_IDLE);

`ifdef FP_ARB_STATS_EN
  for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_stats
    logic [15:0] grants_q;
    always_ff @(posedge clk) begin
      if (rst) begin
        grants_q <= '0;
      end else if (req_ready[gi] && grants_q != 16'hFFFF) begin
        grants_q <= grants_q + 16'd1;
      end
    end
    assign stat_grants[16*gi +: 16] = grants_q;
  end
`else
  assign stat_grants = '0;
`endif

endmodule

// File: tb/tb_fp_op_arbiter.sv
// Directed bench for fp_op_arbiter with a fixed-latency FP unit model and
// hand-computed expected results.
module tb_fp_op_arbiter;
  import fp_pkg::*;

  localparam int N = 3;

  logic            clk = 1'b0;
  logic            rst;
  logic [N-1:0]    req_valid;
  logic [N-1:0]    req_ready;
  logic [2*N-1:0]  req_op;
  logic [32*N-1:0] req_a;
  logic [32*N-1:0] req_b;
  logic [N-1:0]    resp_valid;
  logic [N-1:0]    resp_ready;
  logic [31:0]     resp_data;
  logic            resp_err;
  logic            fu_start;
  logic [1:0]      fu_op;
  logic [31:0]     fu_a;
  logic [31:0]     fu_b;
  logic            fu_done;
  logic [31:0]     fu_result;
  logic            fu_flush;
  logic            busy;
  logic [16*N-1:0] stat_grants;

  fp_op_arbiter #(.NUM_REQ(N), .TIMEOUT(64)) dut (
    .clk         (clk),
    .rst         (rst),
    .req_valid   (req_valid),
    .req_ready   (req_ready),
    .req_op      (req_op),
    .req_a       (req_a),
    .req_b       (req_b),
    .resp_valid  (resp_valid),
    .resp_ready  (resp_ready),
    .resp_data   (resp_data),
    .resp_err    (resp_err),
    .fu_start    (fu_start),
    .fu_op       (fu_op),
    .fu_a        (fu_a),
    .fu_b        (fu_b),
    .fu_done     (fu_done),
    .fu_result   (fu_result),
    .fu_flush    (fu_flush),
    .busy        (busy),
    .stat_grants (stat_grants)
  );

  always #5 clk = ~clk;

  // FP unit model: done pulses k cycles after the fu_start cycle.
  int fu_k = 1;
  bit fu_never = 1'b0;
  bit force_done = 1'b0;
  int rem = 0;

  function automatic logic [31:0] fu_model(input logic [1:0] op, input logic [31:0] a,
                                           input logic [31:0] b);
    if (op == 2'b00 && a == 32'h3F800000 && b == 32'h40000000) return 32'h40400000;
    if (op == 2'b01 && a == 32'h40000000 && b == 32'h40400000) return 32'h40C00000;
    if (op == 2'b10 && a == 32'h3F800000 && b == 32'h40000000) return 32'h3F000000;
    return 32'hDEADBEEF;
  endfunction

  always @(posedge clk) begin
    if (rst) rem <= 0;
    else if (fu_start && !fu_never) rem <= fu_k;
    else if (rem > 0) rem <= rem - 1;
  end

  assign fu_done   = (rem == 1) || force_done;
  assign fu_result = fu_model(fu_op, fu_a, fu_b);

  int checks = 0;
  int failures = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int i, input logic [1:0] op, input logic [31:0] a,
                         input logic [31:0] b);
    req_op[2*i +: 2]  = op;
    req_a[32*i +: 32] = a;
    req_b[32*i +: 32] = b;
  endtask

  task automatic wait_resp(input int bound);
    int n;
    n = 0;
    while (resp_valid == '0 && n < bound) begin
      tick();
      n++;
    end
    if (resp_valid == '0) check("resp_wait_expired", 64'd0, 64'd1);
  endtask

  task automatic accept();
    $display("txn resp_valid=%b data=%h err=%b t=%0t", resp_valid, resp_data, resp_err, $time);
    resp_ready = resp_valid;
    tick();
    resp_ready = '0;
    #1;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired checks=%0d", checks);
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    int order [4];
    logic [63:0] stat_exp;
    order = '{0, 1, 2, 0};
    rst = 1'b1;
    req_valid = '0;
    resp_ready = '0;
    req_op = '0;
    req_a = '0;
    req_b = '0;

    // Reset state
    tick(); tick();
    rst = 1'b0;
    #1;
    check("rst_busy", busy, 0);
    check("rst_req_ready", req_ready, 0);
    check("rst_resp_valid", resp_valid, 0);
    check("rst_fu_start", fu_start, 0);
    check("rst_fu_flush", fu_flush, 0);
    check("rst_resp_data", resp_data, 0);
    check("rst_resp_err", resp_err, 0);
    check("rst_fu_a", fu_a, 0);
    check("rst_stats", stat_grants, 0);

    // Single add, unit latency 3
    set_req(0, OP_ADD, FP_ONE, FP_TWO);
    fu_k = 3;
    req_valid = 3'b001;
    #1;
    check("t1_req_ready", req_ready, 3'b001);
    tick();
    req_valid = '0;
    #1;
    check("t1_fu_start", fu_start, 1);
    check("t1_fu_op", fu_op, OP_ADD);
    check("t1_fu_a", fu_a, 32'h3F800000);
    check("t1_fu_b", fu_b, 32'h40000000);
    check("t1_busy", busy, 1);
    tick();
    check("t1_start_once", fu_start, 0);
    tick(); tick();
    check("t1_no_early_resp", resp_valid, 0);
    tick();
    check("t1_resp_valid", resp_valid, 3'b001);
    check("t1_resp_data", resp_data, 32'h40400000);
    check("t1_resp_err", resp_err, 0);
    accept();
    check("t1_idle", busy, 0);

    // Three continuous multiplies: grant order 0,1,2,0
    rst = 1'b1;
    tick();
    rst = 1'b0;
    for (int i = 0; i < N; i++) set_req(i, OP_MUL, FP_TWO, 32'h40400000);
    fu_k = 2;
    req_valid = '1;
    #1;
    for (int i = 0; i < 4; i++) begin
      if (i == 3) begin
`ifdef FP_ARB_STATS_EN
        stat_exp = {16'd0, 16'd1, 16'd1, 16'd1};
`else
        stat_exp = 64'd0;
`endif
        check("t2_stats", stat_grants, stat_exp);
      end
      check($sformatf("t2_grant%0d", i), req_ready, 64'd1 << order[i]);
      tick();
      wait_resp(20);
      check($sformatf("t2_owner%0d", i), resp_valid, 64'd1 << order[i]);
      check($sformatf("t2_data%0d", i), resp_data, 32'h40C00000);
      check($sformatf("t2_err%0d", i), resp_err, 0);
      if (i == 3) req_valid = '0;
      accept();
    end

    // Divide with a stalled response; req0 waits behind it
    set_req(1, OP_DIV, FP_ONE, FP_TWO);
    set_req(0, OP_ADD, FP_ONE, FP_TWO);
    fu_k = 1;
    req_valid = 3'b010;
    #1;
    check("t3_grant1", req_ready, 3'b010);
    tick();
    req_valid = 3'b001;
    wait_resp(20);
    for (int i = 0; i < 10; i++) begin
      check("t3_hold_valid", resp_valid, 3'b010);
      check("t3_hold_data", resp_data, 32'h3F000000);
      check("t3_no_grant", req_ready, 0);
      tick();
    end
    check("t3_still_valid", resp_valid, 3'b010);
    accept();
    check("t3_grant0_after", req_ready, 3'b001);
    tick();
    req_valid = '0;
    wait_resp(20);
    check("t3_owner0", resp_valid, 3'b001);
    check("t3_data0", resp_data, 32'h40400000);
    accept();

    // Timeout: unit never completes
    set_req(1, OP_ADD, FP_ONE, FP_TWO);
    fu_never = 1'b1;
    req_valid = 3'b010;
    #1;
    check("t4_grant1", req_ready, 3'b010);
    tick();
    req_valid = '0;
    check("t4_start", fu_start, 1);
    n = 0;
    while (fu_flush !== 1'b1 && n < 200) begin
      tick();
      n++;
    end
    check("t4_flush_delay", n, 64);
    tick();
    check("t4_flush_once", fu_flush, 0);
    check("t4_resp_valid", resp_valid, 3'b010);
    check("t4_resp_data", resp_data, 32'h7FC00000);
    check("t4_resp_err", resp_err, 1);
    accept();
    force_done = 1'b1;
    tick();
    force_done = 1'b0;
    #1;
    check("t4_late_done_busy", busy, 0);
    check("t4_late_done_valid", resp_valid, 0);
    check("t4_late_done_data", resp_data, 32'h7FC00000);
    fu_never = 1'b0;

    // Completion on the timeout cycle counts as success
    set_req(2, OP_ADD, FP_ONE, FP_TWO);
    fu_k = 64;
    req_valid = 3'b100;
    #1;
    check("t5_grant2", req_ready, 3'b100);
    tick();
    req_valid = '0;
    n = 0;
    while (fu_done !== 1'b1 && n < 200) begin
      tick();
      n++;
    end
    check("t5_done_delay", n, 64);
    check("t5_no_flush", fu_flush, 0);
    tick();
    check("t5_resp_valid", resp_valid, 3'b100);
    check("t5_resp_data", resp_data, 32'h40400000);
    check("t5_resp_err", resp_err, 0);
    accept();

    // Reserved opcode bypasses the unit
    set_req(2, OP_RSV, FP_ONE, FP_TWO);
    req_valid = 3'b100;
    #1;
    check("t6_grant2", req_ready, 3'b100);
    tick();
    req_valid = '0;
    #1;
    check("t6_no_start", fu_start, 0);
    check("t6_resp_valid", resp_valid, 3'b100);
    check("t6_resp_data", resp_data, 32'h7FC00000);
    check("t6_resp_err", resp_err, 1);
    accept();

    // Reset during WAIT, then pointer restarts at requester 0
    set_req(0, OP_ADD, FP_ONE, FP_TWO);
    set_req(1, OP_ADD, FP_ONE, FP_TWO);
    fu_never = 1'b1;
    fu_k = 1;
    req_valid = 3'b001;
    #1;
    check("t7_grant0", req_ready, 3'b001);
    tick();
    req_valid = '0;
    tick(); tick();
    check("t7_busy_wait", busy, 1);
    rst = 1'b1;
    tick();
    check("t7_rst_busy", busy, 0);
    check("t7_rst_resp_valid", resp_valid, 0);
    check("t7_rst_flush", fu_flush, 0);
    check("t7_rst_start", fu_start, 0);
    check("t7_rst_resp_data", resp_data, 0);
    check("t7_rst_fu_op", fu_op, 0);
    check("t7_rst_fu_a", fu_a, 0);
    check("t7_rst_fu_b", fu_b, 0);
    rst = 1'b0;
    fu_never = 1'b0;
    req_valid = 3'b011;
    #1;
    check("t7_grant_after_rst", req_ready, 3'b001);
    tick();
    req_valid = '0;
    wait_resp(20);
    check("t7_owner0", resp_valid, 3'b001);
    check("t7_data0", resp_data, 32'h40400000);
    accept();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/fp_op_arbiter.md
Name: fp_op_arbiter

Overview:
- Sequential scheduler sharing one single-precision arithmetic unit (add, mul, div; IEEE-754 32-bit) among NUM_REQ requesters.
- Serves one operation at a time: round-robin grant, issues to the unit, waits for completion, returns the result to the owner.
- Sits between series-evaluation engines (cos/sin term generators) and the shared FP unit, so only one costly mul/div instance exists.

Parameters:
- NUM_REQ, 3, number of requesters (2..8).
- TIMEOUT, 64, max cycles in WAIT before an operation is aborted (1..255).

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  synchronous active-high reset.
- req_valid  in  NUM_REQ  per-requester operation request.
- req_ready  out  NUM_REQ  one-hot acceptance pulse.
- req_op  in  2*NUM_REQ  opcode per requester (slice i = [2i+1:2i]).
- req_a  in  32*NUM_REQ  operand A per requester.
- req_b  in  32*NUM_REQ  operand B per requester.
- resp_valid  out  NUM_REQ  one-hot result valid.
- resp_ready  in  NUM_REQ  per-requester result accept.
- resp_data  out  32  result, shared bus.
- resp_err  out  1  result is aborted or reserved-op NaN.
- fu_start  out  1  one-cycle issue pulse to FP unit.
- fu_op  out  2  opcode to unit.
- fu_a, fu_b  out  32 each  operands to unit.
- fu_done  in  1  unit completion pulse.
- fu_result  in  32  unit result, valid with fu_done.
- fu_flush  out  1  one-cycle abort pulse to unit.
- busy  out  1  high in any state except IDLE.
- stat_grants  out  16*NUM_REQ  grant counters (see Optional Feature).

Behaviour:
- Single clock domain. Reset is synchronous and active-high.
- Reset: state=IDLE, rr_ptr=0, owner=0. All req_ready, resp_valid, fu_start and fu_flush are 0. resp_data=0, resp_err=0, fu_op/fu_a/fu_b=0, busy=0.
- Reset mid-operation aborts with no response and no fu_flush; the unit is reset by the same rst.
- FSM states: IDLE, ISSUE, WAIT, RESP.
- IDLE, with any req_valid:
  - Pick the first valid index scanning rr_ptr, rr_ptr+1, ... mod NUM_REQ.
  - Assert req_ready[g] combinationally this cycle.
  - Latch op/a/b into fu_op/fu_a/fu_b; set owner=g and rr_ptr=(g+1) mod NUM_REQ.
  - Next state: ISSUE, or RESP directly if op=OP_RSV.
  - OP_RSV gives resp_data=FP_NAN, resp_err=1.
- ISSUE: fu_start=1 for exactly one cycle; clear the timeout counter; go to WAIT.
- WAIT:
  - Counter increments each cycle.
  - fu_done=1: latch resp_data=fu_result, resp_err=0, go to RESP.
  - Counter reaching TIMEOUT with no done: fu_flush=1 for one cycle, resp_data=FP_NAN, resp_err=1, go to RESP.
  - fu_done in the same cycle the counter reaches TIMEOUT counts as success.
  - fu_done outside WAIT is ignored.
- RESP: resp_valid[owner]=1, held stable with resp_data and resp_err until resp_ready[owner]=1, then go to IDLE.
- Other requesters wait; their req_valid must stay asserted and operands stable until req_ready.
- Latency: accept at cycle T; fu_start at T+1; fu_done at T+1+k gives resp_valid from T+2+k. OP_RSV gives resp_valid at T+1. Minimum request-to-request spacing is 4 cycles for k=1.
- A new grant never occurs while busy=1. At most one req_ready bit and one resp_valid bit are high at a time.
- The arbiter does no arithmetic; operands pass through bit-exact.

Optional Feature:
- Macro FP_ARB_STATS_EN.
- Defined: per-requester 16-bit grant counter, incremented on each req_ready pulse, saturating at 16'hFFFF, cleared by rst; driven on stat_grants slice i = [16i+15:16i].
- Undefined: counters not built, stat_grants tied to 0, port still present.

Decomposition:
- Package fp_pkg:
  - Opcodes OP_ADD=2'b00, OP_MUL=2'b01, OP_DIV=2'b10, OP_RSV=2'b11.
  - Constants FP_ONE=32'h3F800000, FP_TWO=32'h40000000, FP_NAN=32'h7FC00000.
  - FSM state enum.
- Sub-module rr_pick: combinational round-robin picker (inputs valid vector and ptr; outputs one-hot grant, index, any).

Test Plan:
- Req0 OP_ADD a=32'h3F800000, b=32'h40000000, unit model k=3 → fu_start 1 cycle after accept, resp_valid[0] 5 cycles after accept, resp_data=32'h40400000, resp_err=0.
- Req0,1,2 all valid continuously, OP_MUL 2.0×3.0 → grants in order 0,1,2,0; every resp_data=32'h40C00000; each stat_grants slice=1 after three ops (with FP_ARB_STATS_EN defined).
- Req1 OP_DIV 1.0/2.0 with resp_ready held low 10 cycles → resp_valid[1] and resp_data=32'h3F000000 stay stable; req0 is not granted until the response is accepted.
- Unit model never asserts done, TIMEOUT=64 → fu_flush pulse exactly 64 cycles after fu_start, resp_data=32'h7FC00000, resp_err=1; a late fu_done in IDLE has no effect.
- Req2 OP_RSV → no fu_start, resp_valid[2] one cycle after accept, resp_data=FP_NAN, resp_err=1.
- rst asserted in WAIT → next cycle all outputs at reset values; the next request goes to requester 0 first.
